vortex_mem_ahb_sequencer: RTL and testbench
===========================================

// Module: vortex_mem_ahb_sequencer
// PURPOSE
//  Sequences one Vortex 512-bit line memory request at a time onto the 32-bit AHB manager port.
//  - Reads: 16 single-word AHB reads, assembled into a 512-bit response carrying the request tag.
//  - Writes: split per byte-enable into word or byte writes; no response is returned.
//  - Sits between the Vortex memory request/response channel and the wrapper's AHB manager interface.
// PARAMETERS
//  BASE_ADDR   32'h8000_0000  AHB byte address mapped to Vortex line address 0
//  ERR_RDATA   32'h0000_0000  word written into the assembled line when a read data phase returns ERROR
// PORTS
//  clk             in   1    clock
//  reset           in   1    synchronous, active-high reset
//  mem_req_valid   in   1    Vortex request valid
//  mem_req_rw      in   1    1=write, 0=read
//  mem_req_byteen  in   64   byte enables (write only)
//  mem_req_addr    in   26   line address
//  mem_req_data    in   512  write line
//  mem_req_tag     in   56   request tag
//  mem_req_ready   out  1    request accepted this cycle
//  mem_rsp_valid   out  1    read response valid
//  mem_rsp_data    out  512  read line
//  mem_rsp_tag     out  56   tag of completed read
//  mem_rsp_ready   in   1    Vortex accepts response
//  HADDR           out  32   AHB address
//  HWRITE          out  1    AHB write
//  HSIZE           out  3    3'b010 word, 3'b000 byte
//  HTRANS          out  2    2'b00 IDLE, 2'b10 NONSEQ only
//  HWDATA          out  32   write data, driven in data phase
//  HRDATA          in   32   read data
//  HREADY          in   1    transfer/phase complete
//  HRESP           in   1    1=ERROR
//  busy            out  1    state != IDLE
//  err_sticky      out  1    set on any ERROR response
//  err_clr         in   1    clears err_sticky; set has priority if both occur in the same cycle
// BEHAVIOUR
//  Reset values:
//  - All outputs 0: HTRANS=IDLE, HSIZE=0, HADDR=0, mem_rsp_*=0, err_sticky=0.
//  - mem_req_ready=0 on the reset cycle.
//  - State goes to IDLE and captured request state is cleared.
//  - A reset mid-transfer abandons the line; no response is issued.
//  States: IDLE -> ADDR -> DATA -> (ADDR | RESP | IDLE); RESP -> IDLE.
//  IDLE:
//  - mem_req_ready=1; a request is accepted on valid&&ready.
//  - Accept captures rw, addr, byteen, data and tag, and sets word=0, byte=0.
//  - Reads go to ADDR.
//  - Writes scan for the first word/byte with nonzero enables. If all 64 byteen bits are 0: drop the request, stay IDLE.
//  ADDR:
//  - Drive HTRANS=NONSEQ.
//  - HADDR = BASE_ADDR + {addr,6'b0} + word*4 (+ byte for byte writes). 32-bit modulo, wrap allowed.
//  - Advance to DATA when HREADY=1; hold every signal while HREADY=0.
//  DATA:
//  - Drive HTRANS=IDLE. HWDATA = selected word; byte lane = byte index.
//  - The phase completes on HREADY=1. On a read, capture HRDATA into line[word*32 +: 32]. If HRESP=1: use ERR_RDATA and set err_sticky.
//  - Next transfer:
//    - Read: word++. After word 15 go to RESP.
//    - Write, nibble==4'hF: one word write (HSIZE=010).
//    - Write, nibble==4'h0: word skipped.
//    - Write, partial nibble: one byte write (HSIZE=000) per set bit, ascending byte order.
//    - After the last enabled byte of word 15 go to IDLE.
//  RESP:
//  - mem_rsp_valid=1 with data/tag held stable until mem_rsp_ready. Leave RESP on valid&&ready.
//  - No new request is accepted while in RESP.
//  Timing with a zero-wait slave:
//  - Each transfer costs 2 cycles (address phase plus data phase); transfers are not pipelined.
//  - Read: accept -> rsp_valid = 33 cycles. Full-word write line = 32 cycles.
// STRUCTURE
//  Package vortex_mem_ahb_seq_pkg holds:
//  - seq_state_t enum {IDLE, ADDR, DATA, RESP}
//  - HTRANS_IDLE/NONSEQ, HSIZE_BYTE/WORD
//  - WORDS_PER_LINE=16, LINE_W=512, TAG_W=56, LADDR_W=26
//  Sub-module vortex_byteen_planner (combinational):
//  - Inputs: 64-bit byteen, current word and byte.
//  - Outputs: next {word, byte, size, last} pair after the current one.
//  - Used by both the IDLE scan and the DATA advance.
// TESTING
//  1 Read addr=26'h1, tag=56'hA5, zero-wait slave returning HRDATA=word index:
//    -> HADDR 32'h8000_0040..32'h8000_007C step 4; rsp_valid at cycle 33; data[i*32+:32]=i; tag=56'hA5.
//  2 Write, byteen=all 1s, data=pattern:
//    -> 16 word writes (HSIZE=010) with correct HWDATA per data phase; no rsp_valid; back to IDLE after 32 cycles.
//  3 Write, byteen=64'h0000_0000_0000_0005:
//    -> exactly two byte writes, to 32'h8000_0000 and 32'h8000_0002. All-zero byteen -> no AHB activity, ready stays 1.
//  4 Read with HREADY=0 for 3 cycles in word 4's address and data phases:
//    -> HADDR/HTRANS held stable; latency +6 cycles.
//    Then hold rsp_ready=0 for 5 cycles -> rsp data/tag stable, mem_req_ready=0 throughout.
//  5 Read with HRESP=1 on word 7:
//    -> word 7 = ERR_RDATA; err_sticky=1 until err_clr; remaining words still fetched.
//  6 Assert reset during word 9 of a read:
//    -> next cycle HTRANS=IDLE, busy=0, err_sticky=0, no rsp_valid.
//    A subsequent read completes normally.

Source files
------------

// File: rtl/vortex_mem_ahb_seq_pkg.sv
// Shared types and constants for the Vortex line-to-AHB sequencer.
// Latency: none, definitions only.
// Backpressure: n/a.
package vortex_mem_ahb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } seq_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam int WORDS_PER_LINE = 16;
  localparam int LINE_W         = 512;
  localparam int TAG_W          = 56;
  localparam int LADDR_W        = 26;
  localparam int BYTEEN_W       = LINE_W / 8;

endpackage

// File: rtl/vortex_byteen_planner.sv
// Finds the next AHB write transfer (word or single byte) implied by a line byte-enable mask.
// Latency: combinational.
// Backpressure: none; the caller decides when to consume the result.
// Ports: byteen (64-bit mask), from_start (scan from byte 0 inclusive), word/byte_sel/cur_size
//        (the transfer just issued), nxt_word/nxt_byte/nxt_size (next transfer),
//        last (no further enabled byte exists, so nothing more to issue).
module vortex_byteen_planner
  import vortex_mem_ahb_seq_pkg::*;
(
  input  logic [BYTEEN_W-1:0] byteen,
  input  logic                from_start,
  input  logic [3:0]          word,
  input  logic [1:0]          byte_sel,
  input  logic [2:0]          cur_size,
  output logic [3:0]          nxt_word,
  output logic [1:0]          nxt_byte,
  output logic [2:0]          nxt_size,
  output logic                last
);

  logic [6:0]          start;
  logic [BYTEEN_W-1:0] masked;
  logic [5:0]          pos;
  logic [3:0]          nib;

  // A word transfer consumes all four bytes, a byte transfer only its own.
  always_comb begin
    if (from_start)                  start = 7'd0;
    else if (cur_size == HSIZE_WORD) start = {1'b0, word, 2'b00} + 7'd4;
    else                             start = {1'b0, word, byte_sel} + 7'd1;
  end

  // A start of 64 shifts everything out, leaving no candidates.
  assign masked = byteen & ({BYTEEN_W{1'b1}} << start);
  assign last   = (masked == '0);

  always_comb begin
    pos = '0;
    for (int i = BYTEEN_W - 1; i >= 0; i--) begin
      if (masked[i]) pos = 6'(i);
    end
  end

  assign nib      = byteen[{pos[5:2], 2'b00} +: 4];
  assign nxt_word = pos[5:2];

  // A fully enabled word is only ever reached at its byte 0: a scan starts
  // mid-word only after a byte write, which means that word was partial.
  always_comb begin
    if (nib == 4'hF) begin
      nxt_byte = 2'd0;
      nxt_size = HSIZE_WORD;
    end else begin
      nxt_byte = pos[1:0];
      nxt_size = HSIZE_BYTE;
    end
  end

endmodule

// File: rtl/vortex_mem_ahb_sequencer.sv
// Serialises one Vortex 512-bit line request at a time onto a 32-bit AHB manager port.
// Latency: 2 cycles per AHB transfer with a zero-wait slave; read accept -> rsp_valid = 33 cycles.
// Backpressure: mem_req_ready only in IDLE; HREADY=0 freezes the bus phase; RESP holds until mem_rsp_ready.
// Ports: clk/reset (sync, active-high); mem_req_* request channel; mem_rsp_* read response channel;
//        H* AHB manager signals; busy (state != IDLE); err_sticky/err_clr bus-error flag.
module vortex_mem_ahb_sequencer
  import vortex_mem_ahb_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_req_valid,
  input  logic                mem_req_rw,
  input  logic [BYTEEN_W-1:0] mem_req_byteen,
  input  logic [LADDR_W-1:0]  mem_req_addr,
  input  logic [LINE_W-1:0]   mem_req_data,
  input  logic [TAG_W-1:0]    mem_req_tag,
  output logic                mem_req_ready,
  output logic                mem_rsp_valid,
  output logic [LINE_W-1:0]   mem_rsp_data,
  output logic [TAG_W-1:0]    mem_rsp_tag,
  input  logic                mem_rsp_ready,
  output logic [31:0]         HADDR,
  output logic                HWRITE,
  output logic [2:0]          HSIZE,
  output logic [1:0]          HTRANS,
  output logic [31:0]         HWDATA,
  input  logic [31:0]         HRDATA,
  input  logic                HREADY,
  input  logic                HRESP,
  output logic                busy,
  output logic                err_sticky,
  input  logic                err_clr
);

  seq_state_t state, state_nxt;

  logic                rw_q;
  logic [LADDR_W-1:0]  addr_q;
  logic [BYTEEN_W-1:0] byteen_q;
  logic [LINE_W-1:0]   data_q;
  logic [LINE_W-1:0]   line_q;
  logic [TAG_W-1:0]    tag_q;
  logic [3:0]          word_q;
  logic [1:0]          byte_q;
  logic [2:0]          size_q;

  logic                accept;
  logic                xfer_done;
  logic                active;
  logic                plan_last;
  logic [3:0]          plan_word;
  logic [1:0]          plan_byte;
  logic [2:0]          plan_size;

  assign accept    = (state == IDLE) && mem_req_valid && !reset;
  assign xfer_done = (state == DATA) && HREADY;
  assign active    = (state == ADDR) || (state == DATA);

  // In IDLE the planner scans the incoming mask from byte 0; otherwise it
  // advances past the transfer currently in its data phase.
  vortex_byteen_planner u_planner (
    .byteen     ((state == IDLE) ? mem_req_byteen : byteen_q),
    .from_start (state == IDLE),
    .word       (word_q),
    .byte_sel   (byte_q),
    .cur_size   (size_q),
    .nxt_word   (plan_word),
    .nxt_byte   (plan_byte),
    .nxt_size   (plan_size),
    .last       (plan_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    HTRANS        = HTRANS_IDLE;
    unique case (state)
      IDLE: begin
        mem_req_ready = !reset;
        // An all-zero write mask is accepted and dropped without bus activity.
        if (accept && (!mem_req_rw || !plan_last)) state_nxt = ADDR;
      end
      ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        if (HREADY) state_nxt = DATA;
      end
      DATA: begin
        if (HREADY) begin
          if (!rw_q) state_nxt = (word_q == 4'(WORDS_PER_LINE - 1)) ? RESP : ADDR;
          else       state_nxt = plan_last ? IDLE : ADDR;
        end
      end
      RESP: begin
        mem_rsp_valid = 1'b1;
        if (mem_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q       <= 1'b0;
      addr_q     <= '0;
      byteen_q   <= '0;
      data_q     <= '0;
      line_q     <= '0;
      tag_q      <= '0;
      word_q     <= '0;
      byte_q     <= '0;
      size_q     <= HSIZE_WORD;
      err_sticky <= 1'b0;
    end else begin
      // A new error wins over a clear arriving in the same cycle.
      if (xfer_done && HRESP) err_sticky <= 1'b1;
      else if (err_clr)       err_sticky <= 1'b0;

      if (accept) begin
        rw_q     <= mem_req_rw;
        addr_q   <= mem_req_addr;
        byteen_q <= mem_req_byteen;
        data_q   <= mem_req_data;
        tag_q    <= mem_req_tag;
        if (mem_req_rw) begin
          word_q <= plan_word;
          byte_q <= plan_byte;
          size_q <= plan_size;
        end else begin
          word_q <= '0;
          byte_q <= '0;
          size_q <= HSIZE_WORD;
        end
      end

      if (xfer_done) begin
        if (!rw_q) begin
          line_q[{word_q, 5'b0} +: 32] <= HRESP ? ERR_RDATA : HRDATA;
          word_q                       <= word_q + 4'd1;
        end else begin
          word_q <= plan_word;
          byte_q <= plan_byte;
          size_q <= plan_size;
        end
      end
    end
  end

  // Address is held through the data phase so a stalled slave sees it stable.
  assign HADDR  = active ? (BASE_ADDR + {addr_q, 6'b0} + {26'b0, word_q, 2'b00} + {30'b0, byte_q})
                         : 32'h0;
  assign HWRITE = active && rw_q;
  assign HSIZE  = active ? size_q : 3'b000;
  // Full word is driven; for byte writes the addressed lane carries the byte.
  assign HWDATA = ((state == DATA) && rw_q) ? data_q[{word_q, 5'b0} +: 32] : 32'h0;

  assign mem_rsp_data = (state == RESP) ? line_q : '0;
  assign mem_rsp_tag  = (state == RESP) ? tag_q  : '0;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_vortex_mem_ahb_sequencer.sv
module tb_vortex_mem_ahb_sequencer;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req_valid;
  logic          mem_req_rw;
  logic [63:0]   mem_req_byteen;
  logic [25:0]   mem_req_addr;
  logic [511:0]  mem_req_data;
  logic [55:0]   mem_req_tag;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [511:0]  mem_rsp_data;
  logic [55:0]   mem_rsp_tag;
  logic          mem_rsp_ready;
  logic [31:0]   HADDR;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [1:0]    HTRANS;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic          HREADY;
  logic          HRESP;
  logic          busy;
  logic          err_sticky;
  logic          err_clr;

  always #5 clk = ~clk;

  vortex_mem_ahb_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .HADDR          (HADDR),
    .HWRITE         (HWRITE),
    .HSIZE          (HSIZE),
    .HTRANS         (HTRANS),
    .HWDATA         (HWDATA),
    .HRDATA         (HRDATA),
    .HREADY         (HREADY),
    .HRESP          (HRESP),
    .busy           (busy),
    .err_sticky     (err_sticky),
    .err_clr        (err_clr)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_acc = 0;

  // slave model / monitor state
  bit           dphase      = 1'b0;
  logic [3:0]   dword       = '0;
  int           stall_word  = -1;
  int           err_word    = -1;
  int           astall      = 0;
  int           dstall      = 0;
  bit           clr_with_err = 1'b0;
  bit           a_held      = 1'b0;
  logic [31:0]  held_addr   = '0;
  bit           rsp_seen    = 1'b0;
  int           rsp_cyc     = 0;
  logic [511:0] rsp_data    = '0;
  logic [55:0]  rsp_tag     = '0;
  logic [31:0]  xa[$];
  logic [2:0]   xs[$];
  bit           xw[$];
  logic [31:0]  xd[$];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qa(input int i);
    return (xa.size() > i) ? xa[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] qd(input int i);
    return (xd.size() > i) ? xd[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [2:0] qs(input int i);
    return (xs.size() > i) ? xs[i] : 3'bxxx;
  endfunction

  function automatic logic [511:0] exp_line(input int errw);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = (i == errw) ? 32'h0 : 32'(i);
    return l;
  endfunction

  // One clock: sample #1 after the edge, then act as slave for the coming cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (a_held) begin
      chk("stall_haddr_held", HADDR, held_addr);
      chk("stall_htrans_held", HTRANS, 2'b10);
    end
    a_held  = 1'b0;
    HREADY  = 1'b1;
    HRESP   = 1'b0;
    err_clr = 1'b0;
    if (dphase) begin
      if (int'(dword) == stall_word && dstall < 3) begin HREADY = 1'b0; dstall++; end
      if (int'(dword) == err_word) begin HRESP = 1'b1; err_clr = clr_with_err; end
      if (HREADY) begin
        if (xw.size() > 0 && xw[xw.size()-1]) xd.push_back(HWDATA);
        dphase = 1'b0;
      end
    end else if (HTRANS == 2'b10) begin
      if (int'(HADDR[5:2]) == stall_word && astall < 3) begin
        HREADY = 1'b0; astall++; a_held = 1'b1; held_addr = HADDR;
      end
      if (HREADY) begin
        xa.push_back(HADDR);
        xs.push_back(HSIZE);
        xw.push_back(HWRITE);
        dphase = 1'b1;
        dword  = HADDR[5:2];
        HRDATA = {28'h0, HADDR[5:2]};
      end
    end
    if (mem_rsp_valid && !rsp_seen) begin
      rsp_seen = 1'b1;
      rsp_cyc  = cyc;
      rsp_data = mem_rsp_data;
      rsp_tag  = mem_rsp_tag;
    end
  endtask

  task automatic send(input logic rw, input logic [25:0] a, input logic [63:0] be,
                      input logic [511:0] d, input logic [55:0] t);
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = a;
    mem_req_byteen = be;
    mem_req_data   = d;
    mem_req_tag    = t;
    rsp_seen = 1'b0;
    astall = 0;
    dstall = 0;
    xa.delete(); xs.delete(); xw.delete(); xd.delete();
    #1;
    chk("req_ready_in_idle", mem_req_ready, 1'b1);
    t_acc = cyc;
    step();
    mem_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 100 && !rsp_seen; i++) step();
    chk(tag, rsp_seen, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin n++; step(); end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] pat;
    int bc;
    bit found;

    reset = 1'b1;
    mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_byteen = '0; mem_req_addr = '0;
    mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 1'b1;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0; err_clr = 1'b0;

    // reset state
    step(); step(); step();
    chk("rst_req_ready", mem_req_ready, 1'b0);
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hsize", HSIZE, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", mem_rsp_valid, 1'b0);
    chk("rst_rsp_data", mem_rsp_data, 512'h0);
    chk("rst_err_sticky", err_sticky, 1'b0);
    reset = 1'b0;
    step();

    // 1: plain read, zero-wait slave
    send(1'b0, 26'h1, 64'h0, 512'h0, 56'hA5);
    wait_rsp("t1_rsp_seen");
    chk("t1_latency", rsp_cyc - t_acc, 33);
    chk("t1_tag", rsp_tag, 56'hA5);
    chk("t1_data", rsp_data, exp_line(-1));
    chk("t1_xfer_count", xa.size(), 16);
    for (int i = 0; i < 16; i++) chk("t1_haddr", qa(i), 32'h8000_0040 + 32'(4 * i));
    chk("t1_hsize", qs(0), 3'b010);
    chk("t1_hwrite", (xw.size() > 0) ? xw[0] : 1'b1, 1'b0);
    step();
    chk("t1_idle_after", busy, 1'b0);

    // 2: full-line write
    for (int i = 0; i < 16; i++) pat[i*32 +: 32] = 32'hD000_0000 + 32'(i);
    send(1'b1, 26'h2, {64{1'b1}}, pat, 56'h0);
    bc = 0;
    while (busy && bc < 100) begin bc++; step(); end
    chk("t2_busy_cycles", bc, 32);
    chk("t2_xfer_count", xa.size(), 16);
    chk("t2_data_count", xd.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("t2_haddr", qa(i), 32'h8000_0080 + 32'(4 * i));
      chk("t2_hwdata", qd(i), 32'hD000_0000 + 32'(i));
      chk("t2_hsize", qs(i), 3'b010);
    end
    chk("t2_no_rsp", rsp_seen, 1'b0);

    // 3: sparse byte enables, then an all-zero mask
    pat = '0;
    pat[31:0] = 32'h4433_2211;
    send(1'b1, 26'h0, 64'h5, pat, 56'h0);
    wait_idle("t3_done");
    chk("t3_xfer_count", xa.size(), 2);
    chk("t3_addr0", qa(0), 32'h8000_0000);
    chk("t3_addr1", qa(1), 32'h8000_0002);
    chk("t3_size0", qs(0), 3'b000);
    chk("t3_size1", qs(1), 3'b000);
    chk("t3_wdata0", qd(0), 32'h4433_2211);
    send(1'b1, 26'h0, 64'h0, pat, 56'h0);
    chk("t3_zero_busy", busy, 1'b0);
    chk("t3_zero_ready", mem_req_ready, 1'b1);
    step(); step(); step();
    chk("t3_zero_no_xfer", xa.size(), 0);

    // 4: wait states on word 4, then response backpressure
    stall_word = 4;
    mem_rsp_ready = 1'b0;
    send(1'b0, 26'h3, 64'h0, 512'h0, 56'h1234);
    wait_rsp("t4_rsp_seen");
    stall_word = -1;
    chk("t4_latency", rsp_cyc - t_acc, 39);
    chk("t4_data", rsp_data, exp_line(-1));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_hold_valid", mem_rsp_valid, 1'b1);
      chk("t4_hold_data", mem_rsp_data, exp_line(-1));
      chk("t4_hold_tag", mem_rsp_tag, 56'h1234);
      chk("t4_hold_req_ready", mem_req_ready, 1'b0);
    end
    mem_rsp_ready = 1'b1;
    step();
    chk("t4_rsp_released", mem_rsp_valid, 1'b0);
    chk("t4_idle", busy, 1'b0);

    // 5: ERROR on word 7, with a clear in the same cycle as the error
    err_word = 7;
    clr_with_err = 1'b1;
    send(1'b0, 26'h5, 64'h0, 512'h0, 56'h55);
    wait_rsp("t5_rsp_seen");
    err_word = -1;
    clr_with_err = 1'b0;
    chk("t5_data", rsp_data, exp_line(7));
    chk("t5_xfer_count", xa.size(), 16);
    chk("t5_err_set_wins", err_sticky, 1'b1);
    step();
    chk("t5_err_sticky", err_sticky, 1'b1);
    err_clr = 1'b1;
    step();
    chk("t5_err_cleared", err_sticky, 1'b0);

    // 6: reset during word 9 of a read, then a read at the top line address
    err_word = 2;
    send(1'b0, 26'h7, 64'h0, 512'h0, 56'h66);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (HTRANS == 2'b10 && HADDR[5:2] == 4'd9) found = 1'b1;
      else step();
    end
    chk("t6_reached_word9", found, 1'b1);
    chk("t6_err_before_reset", err_sticky, 1'b1);
    err_word = -1;
    reset = 1'b1;
    step();
    chk("t6_ready_in_reset", mem_req_ready, 1'b0);
    reset = 1'b0;
    dphase = 1'b0;
    chk("t6_htrans", HTRANS, 2'b00);
    chk("t6_busy", busy, 1'b0);
    chk("t6_err_cleared", err_sticky, 1'b0);
    chk("t6_rsp_valid", mem_rsp_valid, 1'b0);
    for (int i = 0; i < 40; i++) step();
    chk("t6_no_rsp", rsp_seen, 1'b0);
    send(1'b0, 26'h3FF_FFFF, 64'h0, 512'h0, 56'hFF_FFFF_FFFF_FFFF);
    wait_rsp("t6_rsp_seen");
    chk("t6_latency", rsp_cyc - t_acc, 33);
    chk("t6_tag", rsp_tag, 56'hFF_FFFF_FFFF_FFFF);
    chk("t6_data", rsp_data, exp_line(-1));
    chk("t6_wrap_first", qa(0), 32'h7FFF_FFC0);
    chk("t6_wrap_last", qa(15), 32'h7FFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
